// File: rtl/signal_debouncer_pkg.sv
// Shared definitions for the signal debouncer: FSM state encoding, legal
// parameter ranges and small elaboration-time helpers.
package signal_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'b00,
    CHECK_HIGH = 2'b01,
    IDLE_HIGH  = 2'b11,
    CHECK_LOW  = 2'b10
  } state_e;

  localparam int SyncStagesMin     = 2;
  localparam int SyncStagesMax     = 4;
  localparam int DebounceCyclesMin = 2;
  localparam int DebounceCyclesMax = 65535;

  function automatic bit syncStagesOk(input int stages);
    return (stages >= SyncStagesMin) && (stages <= SyncStagesMax);
  endfunction

  function automatic bit debounceCyclesOk(input int cycles);
    return (cycles >= DebounceCyclesMin) && (cycles <= DebounceCyclesMax);
  endfunction

  // The run counter never reaches N, so clog2(N) bits always suffice.
  function automatic int countWidth(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  function automatic state_e idleState(input logic level);
    return level ? IDLE_HIGH : IDLE_LOW;
  endfunction

endpackage

// File: rtl/signal_synchronizer.sv
// Multi-stage flop chain that brings an asynchronous input into the
// i_CLOCK_POS domain; the last stage is the only safe tap.
module signal_synchronizer
  import signal_debouncer_pkg::*;
#(
  parameter int   p_SYNC_STAGES = 2,
  parameter logic p_INIT        = 1'b0
) (
  input  logic i_CLOCK_POS,
  input  logic i_RESET_NEG,
  input  logic i_SIGNAL_IN,
  output logic o_SIGNAL_OUT
);

  logic [p_SYNC_STAGES-1:0] syncChain_q;

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      syncChain_q <= {p_SYNC_STAGES{p_INIT}};
    end else begin
      syncChain_q <= {syncChain_q[p_SYNC_STAGES-2:0], i_SIGNAL_IN};
    end
  end

  assign o_SIGNAL_OUT = syncChain_q[p_SYNC_STAGES-1];

  if (!syncStagesOk(p_SYNC_STAGES)) begin : gBadStages
    $error("signal_synchronizer: p_SYNC_STAGES must be in 2..4");
  end

endmodule

// File: rtl/signal_debouncer.sv
// Debouncer: synchronizer, run-length counter and four-state FSM producing a
// clean registered level plus single-cycle rise/fall pulses.
module signal_debouncer
  import signal_debouncer_pkg::*;
#(
  parameter int   p_SYNC_STAGES     = 2,
  parameter int   p_DEBOUNCE_CYCLES = 16,
  parameter logic p_INIT            = 1'b0
) (
  input  logic i_CLOCK_POS,
  input  logic i_RESET_NEG,
  input  logic i_SIGNAL_IN,
  input  logic i_ENABLE,
  output logic o_SIGNAL_OUT,
  output logic o_RISE_PULSE,
  output logic o_FALL_PULSE,
  output logic o_STABLE
);

  localparam int                CountW     = countWidth(p_DEBOUNCE_CYCLES);
  localparam logic [CountW-1:0] FirstCount = CountW'(1);
  localparam logic [CountW-1:0] LastCount  = CountW'(p_DEBOUNCE_CYCLES - 1);
  localparam state_e            ResetState = idleState(p_INIT);

  logic              syncedIn;
  state_e            state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              stable_q, stable_d;

  signal_synchronizer #(
    .p_SYNC_STAGES(p_SYNC_STAGES),
    .p_INIT       (p_INIT)
  ) uSync (
    .i_CLOCK_POS (i_CLOCK_POS),
    .i_RESET_NEG (i_RESET_NEG),
    .i_SIGNAL_IN (i_SIGNAL_IN),
    .o_SIGNAL_OUT(syncedIn)
  );

  // A glitch or a dropped enable sends the FSM back to the IDLE state that
  // matches the accepted level, so every new attempt counts a full N.
  always_comb begin
    state_d = state_q;
    count_d = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!i_ENABLE) begin
      state_d = idleState(level_q);
    end else begin
      case (state_q)
        IDLE_LOW: begin
          if (syncedIn) begin
            state_d = CHECK_HIGH;
            count_d = FirstCount;
          end
        end
        IDLE_HIGH: begin
          if (!syncedIn) begin
            state_d = CHECK_LOW;
            count_d = FirstCount;
          end
        end
        CHECK_HIGH: begin
          if (!syncedIn) begin
            state_d = IDLE_LOW;
          end else if (count_q == LastCount) begin
            state_d = IDLE_HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            count_d = count_q + FirstCount;
          end
        end
        CHECK_LOW: begin
          if (syncedIn) begin
            state_d = IDLE_HIGH;
          end else if (count_q == LastCount) begin
            state_d = IDLE_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            count_d = count_q + FirstCount;
          end
        end
        default: begin
          state_d = idleState(level_q);
        end
      endcase
    end
    stable_d = (state_d == IDLE_LOW) || (state_d == IDLE_HIGH);
  end

  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG) begin
    if (!i_RESET_NEG) begin
      state_q  <= ResetState;
      count_q  <= '0;
      level_q  <= p_INIT;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      stable_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      stable_q <= stable_d;
    end
  end

  assign o_SIGNAL_OUT = level_q;
  assign o_RISE_PULSE = rise_q;
  assign o_FALL_PULSE = fall_q;
  assign o_STABLE     = stable_q;

  if (!syncStagesOk(p_SYNC_STAGES) || !debounceCyclesOk(p_DEBOUNCE_CYCLES)) begin : gBadParams
    $error("signal_debouncer: p_SYNC_STAGES must be 2..4 and p_DEBOUNCE_CYCLES 2..65535");
  end

endmodule

// File: tb/tb_signal_debouncer.sv
// Directed bench for signal_debouncer: four instances with different
// parameters, expectations queued per clock edge and checked on the falling edge.
module tb_signal_debouncer;

  typedef struct {
    string      tag;
    int         dut;
    int         atEdge;
    logic [3:0] exp;
  } item_t;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  logic sig0 = 1'b0, sig1 = 1'b0, sig2 = 1'b0, sig3 = 1'b0;
  logic en0 = 1'b1, en1 = 1'b1, en2 = 1'b1, en3 = 1'b1;
  logic out0, rise0, fall0, stab0;
  logic out1, rise1, fall1, stab1;
  logic out2, rise2, fall2, stab2;
  logic out3, rise3, fall3, stab3;
  logic [3:0] obs [4];

  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  item_t sb[$];

  // Defaults, init 0
  signal_debouncer #(.p_SYNC_STAGES(2), .p_DEBOUNCE_CYCLES(16), .p_INIT(1'b0)) dut0 (
    .i_CLOCK_POS(clock), .i_RESET_NEG(resetN), .i_SIGNAL_IN(sig0), .i_ENABLE(en0),
    .o_SIGNAL_OUT(out0), .o_RISE_PULSE(rise0), .o_FALL_PULSE(fall0), .o_STABLE(stab0));
  signal_debouncer #(.p_SYNC_STAGES(2), .p_DEBOUNCE_CYCLES(4), .p_INIT(1'b0)) dut1 (
    .i_CLOCK_POS(clock), .i_RESET_NEG(resetN), .i_SIGNAL_IN(sig1), .i_ENABLE(en1),
    .o_SIGNAL_OUT(out1), .o_RISE_PULSE(rise1), .o_FALL_PULSE(fall1), .o_STABLE(stab1));
  signal_debouncer #(.p_SYNC_STAGES(3), .p_DEBOUNCE_CYCLES(2), .p_INIT(1'b0)) dut2 (
    .i_CLOCK_POS(clock), .i_RESET_NEG(resetN), .i_SIGNAL_IN(sig2), .i_ENABLE(en2),
    .o_SIGNAL_OUT(out2), .o_RISE_PULSE(rise2), .o_FALL_PULSE(fall2), .o_STABLE(stab2));
  signal_debouncer #(.p_SYNC_STAGES(2), .p_DEBOUNCE_CYCLES(16), .p_INIT(1'b1)) dut3 (
    .i_CLOCK_POS(clock), .i_RESET_NEG(resetN), .i_SIGNAL_IN(sig3), .i_ENABLE(en3),
    .o_SIGNAL_OUT(out3), .o_RISE_PULSE(rise3), .o_FALL_PULSE(fall3), .o_STABLE(stab3));

  assign obs[0] = {out0, rise0, fall0, stab0};
  assign obs[1] = {out1, rise1, fall1, stab1};
  assign obs[2] = {out2, rise2, fall2, stab2};
  assign obs[3] = {out3, rise3, fall3, stab3};

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Expectations are keyed by rising-edge number; at the falling edge after
  // edge k every item due at k is compared and retired.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].atEdge <= cyc) begin
        checks++;
        assert (sb[i].atEdge == cyc && obs[sb[i].dut] === sb[i].exp) else begin
          errors++;
          $error("[TB] FAIL %s dut%0d edge %0d: observed {out,rise,fall,stable}=%b expected=%b",
                 sb[i].tag, sb[i].dut, sb[i].atEdge, obs[sb[i].dut], sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic checkOutput(input string tag, input int dut, input int fromEdge,
                             input int toEdge, input logic [3:0] exp);
    for (int e = fromEdge; e <= toEdge; e++) sb.push_back('{tag, dut, e, exp});
  endtask

  task automatic applyStimulus(input int dut, input logic value, output int capEdge);
    case (dut)
      0: sig0 = value;
      1: sig1 = value;
      2: sig2 = value;
      default: sig3 = value;
    endcase
    capEdge = cyc + 1;
  endtask

  task automatic atNeg(input int e);
    while (cyc < e) @(negedge clock);
  endtask

  initial begin
    int r;
    int r3;
    int guard;

    $display("[TB] reset with bouncing inputs");
    checkOutput("rst_hold0", 0, 1, 6, 4'b0001);
    checkOutput("rst_hold3", 3, 1, 6, 4'b1001);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      sig0 = ~sig0; sig1 = ~sig1; sig2 = ~sig2; sig3 = ~sig3;
    end
    sig0 = 1'b0; sig1 = 1'b0; sig2 = 1'b0; sig3 = 1'b1;
    resetN = 1'b1;
    checkOutput("post_rst0", 0, 7, 12, 4'b0001);
    checkOutput("post_rst3", 3, 7, 12, 4'b1001);
    atNeg(12);

    $display("[TB] clean rise dut0, clean fall dut3");
    applyStimulus(0, 1'b1, r);
    applyStimulus(3, 1'b0, r3);
    checkOutput("rise_pre",  0, r,      r + 1,  4'b0001);
    checkOutput("rise_chk",  0, r + 2,  r + 16, 4'b0000);
    checkOutput("rise_acc",  0, r + 17, r + 17, 4'b1101);
    checkOutput("rise_post", 0, r + 18, r + 19, 4'b1001);
    checkOutput("fall3_chk",  3, r3 + 2,  r3 + 16, 4'b1000);
    checkOutput("fall3_acc",  3, r3 + 17, r3 + 17, 4'b0011);
    checkOutput("fall3_post", 3, r3 + 18, r3 + 19, 4'b0001);
    atNeg(r + 20);

    applyStimulus(0, 1'b0, r);
    checkOutput("fall_chk",  0, r + 2,  r + 16, 4'b1000);
    checkOutput("fall_acc",  0, r + 17, r + 17, 4'b0011);
    checkOutput("fall_post", 0, r + 18, r + 19, 4'b0001);
    atNeg(r + 20);

    $display("[TB] bounce rejection dut1 (N=4)");
    applyStimulus(1, 1'b1, r);
    checkOutput("bnc_pre",   1, r,      r + 1,  4'b0001);
    checkOutput("bnc_chk1",  1, r + 2,  r + 4,  4'b0000);
    checkOutput("bnc_rej",   1, r + 5,  r + 5,  4'b0001);
    checkOutput("bnc_chk2",  1, r + 6,  r + 8,  4'b0000);
    checkOutput("bnc_acc",   1, r + 9,  r + 9,  4'b1101);
    checkOutput("bnc_post",  1, r + 10, r + 12, 4'b1001);
    atNeg(r + 2);
    sig1 = 1'b0;
    atNeg(r + 3);
    sig1 = 1'b1;
    atNeg(r + 13);

    $display("[TB] enable gating dut0");
    applyStimulus(0, 1'b1, r);
    checkOutput("en_pre",    0, r,      r + 1,  4'b0001);
    checkOutput("en_chk1",   0, r + 2,  r + 8,  4'b0000);
    checkOutput("en_off",    0, r + 9,  r + 11, 4'b0001);
    checkOutput("en_chk2",   0, r + 12, r + 26, 4'b0000);
    checkOutput("en_acc",    0, r + 27, r + 27, 4'b1101);
    checkOutput("en_post",   0, r + 28, r + 29, 4'b1001);
    atNeg(r + 8);
    en0 = 1'b0;
    atNeg(r + 11);
    en0 = 1'b1;
    atNeg(r + 30);
    applyStimulus(0, 1'b0, r);
    checkOutput("en_fall_chk", 0, r + 2,  r + 16, 4'b1000);
    checkOutput("en_fall_acc", 0, r + 17, r + 17, 4'b0011);
    atNeg(r + 19);

    $display("[TB] back-to-back dut2 (3 stages, N=2)");
    applyStimulus(2, 1'b1, r);
    checkOutput("b2b_pre",   2, r,     r + 2, 4'b0001);
    checkOutput("b2b_chk",   2, r + 3, r + 3, 4'b0000);
    checkOutput("b2b_rise",  2, r + 4, r + 4, 4'b1101);
    checkOutput("b2b_chk2",  2, r + 5, r + 5, 4'b1000);
    checkOutput("b2b_fall",  2, r + 6, r + 6, 4'b0011);
    checkOutput("b2b_post",  2, r + 7, r + 8, 4'b0001);
    atNeg(r + 1);
    sig2 = 1'b0;
    atNeg(r + 9);

    $display("[TB] reset mid-count dut0");
    applyStimulus(0, 1'b1, r);
    checkOutput("mid_pre",   0, r,      r + 1,  4'b0001);
    checkOutput("mid_chk",   0, r + 2,  r + 11, 4'b0000);
    checkOutput("mid_rst",   0, r + 12, r + 13, 4'b0001);
    checkOutput("mid_sync",  0, r + 14, r + 15, 4'b0001);
    checkOutput("mid_chk2",  0, r + 16, r + 30, 4'b0000);
    checkOutput("mid_acc",   0, r + 31, r + 31, 4'b1101);
    checkOutput("mid_post",  0, r + 32, r + 33, 4'b1001);
    atNeg(r + 11);
    #2 resetN = 1'b0;
    #1;
    checks++;
    assert (obs[0] === 4'b0001) else begin
      errors++;
      $error("[TB] FAIL async_rst: observed {out,rise,fall,stable}=%b expected=%b", obs[0], 4'b0001);
    end
    atNeg(r + 13);
    resetN = 1'b1;
    atNeg(r + 34);

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clock);
      #1;
      guard++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("[TB] FAIL drain: observed %0d pending checks, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/signal_debouncer.md
# signal_debouncer

Conditions a raw, asynchronous, bouncy input (push-button, switch, external strobe) into a clean, clock-synchronous level plus single-cycle edge pulses. It sits directly upstream of the team's D flip-flop stages: o_SIGNAL_OUT drives their data input, and the pulses drive enables. Internally it chains a multi-stage synchronizer, a run-length counter and a four-state FSM.

## Interface
- p_SYNC_STAGES, 2: synchronizer depth; legal range 2..4.
- p_DEBOUNCE_CYCLES, 16: consecutive stable cycles N required to accept a new level; legal range 2..65535.
- p_INIT, 1'b0: reset value of the synchronizer chain and of the output level.
- i_CLOCK_POS  input  1  clock; all state updates on its rising edge.
- i_RESET_NEG  input  1  reset, asynchronous, active-low.
- i_SIGNAL_IN  input  1  raw asynchronous input.
- i_ENABLE  input  1  high = debouncing active; low = freeze the accepted level.
- o_SIGNAL_OUT  output  1  debounced level.
- o_RISE_PULSE  output  1  one-cycle pulse when o_SIGNAL_OUT goes 0->1.
- o_FALL_PULSE  output  1  one-cycle pulse when o_SIGNAL_OUT goes 1->0.
- o_STABLE  output  1  high while no candidate transition is being counted.

## Operation
- Synchronizer: a p_SYNC_STAGES flop chain samples i_SIGNAL_IN. Its last stage is s. The chain keeps running regardless of i_ENABLE.
- Counter width is clog2(p_DEBOUNCE_CYCLES). The counter saturates at no point: it is cleared before it can reach N.
- FSM states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW.
- IDLE_x, s equal to the output: stay; count = 0.
- IDLE_x, s different from the output, i_ENABLE = 1: go to CHECK_(other); count = 1.
- CHECK_x, s still the new value, count < N-1: count++.
- CHECK_x, s still the new value, count == N-1: go to IDLE_(new). At the same edge, toggle o_SIGNAL_OUT, pulse the matching edge output, and set count = 0.
- CHECK_x, s reverts: the glitch is rejected. Return to the originating IDLE state; count = 0; no pulse.
- i_ENABLE = 0 in any state: next state is the IDLE state matching o_SIGNAL_OUT; count = 0; outputs hold; no pulses.
- o_STABLE = 1 exactly in IDLE states.
- o_RISE_PULSE and o_FALL_PULSE are registered, mutually exclusive, and high for exactly one cycle.

## Timing
- Reset (asynchronous assert): all sync stages = p_INIT; o_SIGNAL_OUT = p_INIT; state = IDLE_LOW if p_INIT = 0, else IDLE_HIGH; count = 0; o_RISE_PULSE = o_FALL_PULSE = 0; o_STABLE = 1.
- Reset deassertion is expected synchronous to i_CLOCK_POS; it is supplied by the system reset synchronizer.
- Reset asserted mid-count discards the count immediately; no pulse is emitted.
- Latency: i_SIGNAL_IN changes and then holds, and is first captured at edge R. s changes at edge R+p_SYNC_STAGES-1. The FSM enters CHECK at edge R+p_SYNC_STAGES. o_SIGNAL_OUT and the pulse update at edge R+p_SYNC_STAGES+N-1. With defaults (2 stages, N = 16) that is R+17.
- Acceptance rule: s must hold the new value at N consecutive rising edges. A reversion at any of those edges restarts the full N-cycle count.
- Back-to-back transitions: after acceptance the FSM is in IDLE. An opposite change of s at the very next edge starts a new count; there are no dead cycles.
- i_ENABLE deasserted during CHECK aborts the count at that edge. When it is reasserted, a still-different s starts a fresh count of N.
- Outputs are glitch-free registers; there are no combinational paths from inputs to outputs.

## Structure
- Shared package signal_debouncer_pkg holds:
  - state encoding constants: 2-bit, IDLE_LOW=00, CHECK_HIGH=01, IDLE_HIGH=11, CHECK_LOW=10;
  - parameter range checks.
- Sub-module signal_synchronizer(p_SYNC_STAGES, p_INIT) implements the flop chain. It is reused by other input-facing blocks.
- Top level holds the FSM, the counter and the output registers, with an elaboration-time check that parameters are in range.

## Test plan
- Reset, p_INIT=0: hold i_RESET_NEG low while toggling i_SIGNAL_IN -> o_SIGNAL_OUT=0, o_STABLE=1, both pulses 0 throughout.
- Clean rise, defaults: i_SIGNAL_IN 0->1 captured at edge R and held -> o_SIGNAL_OUT=1 and o_RISE_PULSE=1 at edge R+17 only; o_STABLE=0 from edge R+2 through R+16.
- Bounce rejection, N=4: s high for 3 edges, then low 1, then high 5 -> exactly one rise, occurring on the 4th consecutive high edge of the final run; no fall pulse.
- Enable gating: i_ENABLE=0 during a CHECK at count 7 -> output held, state returns to IDLE, o_STABLE=1. Re-enable with input still high -> rise occurs N edges later, not 16-7.
- Reset mid-count: assert i_RESET_NEG at count 10 of a rise -> o_SIGNAL_OUT stays 0 asynchronously, no pulse. After release with input still high -> rise occurs p_SYNC_STAGES+N-1 edges after the first capture edge.
- Back-to-back with N=2 and p_SYNC_STAGES=3: a 1 pulse lasting 2 cycles followed by a 0 -> rise pulse, then a fall pulse exactly 2 edges later.
